// File: rtl/snake_feeder_ctrl.sv
// Streams NW weight words, then the feature map in snake order (two-row head, serpentine body) to the chip.
// Feature beats appear 1 cycle after the read; reads throttle so at most 2 words sit in the skid FIFO or in flight.
module snake_feeder_ctrl #(
    parameter int ROW = 128,
    parameter int COL = 128,
    parameter int DW  = 32,
    parameter int WW  = 768,
    parameter int NW  = 12,
    parameter int AW  = $clog2(ROW*COL)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          w_rd_en,
    output logic [3:0]    w_addr,
    input  logic [WW-1:0] w_rdata,
    output logic [WW-1:0] weight_out,
    output logic          weight_valid,
    output logic          f_rd_en,
    output logic [AW-1:0] f_addr,
    input  logic [DW-1:0] f_rdata,
    output logic [DW-1:0] data_out,
    output logic          data_valid,
    input  logic          data_ready,
    output logic          data_last
);

    localparam int RW = $clog2(ROW + 1);
    localparam int CW = $clog2(COL + 1);
    localparam int BW = $clog2(ROW * COL + 1);
    localparam logic [RW-1:0] ROW_END  = RW'(ROW - 1);
    localparam logic [CW-1:0] COL_END  = CW'(COL - 1);
    localparam logic [BW-1:0] BEAT_END = BW'(ROW * COL - 1);
    localparam logic [3:0]    K_END    = 4'(NW - 1);

    typedef enum logic [2:0] {IDLE, WLOAD, HEAD, BODY, DRAIN} state_t;

    state_t        state, state_n;
    logic [3:0]    k, k_n;
    logic [RW-1:0] row, row_n;
    logic [CW-1:0] col, col_n;
    logic [BW-1:0] beat;
    logic          wv, rd_pend, done_q, done_n;
    logic [1:0]    occ;
    logic [DW-1:0] fifo [2];
    logic          rd_ptr, wr_ptr;
    logic          accept, push, pop, room;

    assign busy         = (state != IDLE);
    assign done         = done_q;
    assign w_addr       = k;
    assign weight_valid = wv;
    assign weight_out   = wv ? w_rdata : '0;
    assign f_addr       = AW'(row) * AW'(COL) + AW'(col);

    // Returning read data bypasses the FIFO when it is empty; it is captured only if the chip stalls.
    assign data_valid = (occ != 2'd0) | rd_pend;
    assign data_out   = (occ != 2'd0) ? fifo[rd_ptr] : (rd_pend ? f_rdata : '0);
    assign data_last  = data_valid & (beat == BEAT_END);
    assign accept     = data_valid & data_ready;
    assign room       = ((occ + {1'b0, rd_pend}) < 2'd2) | accept;
    assign push       = rd_pend & ~((occ == 2'd0) & accept);
    assign pop        = accept & (occ != 2'd0);

    always_comb begin
        state_n = state;
        k_n     = k;
        row_n   = row;
        col_n   = col;
        w_rd_en = 1'b0;
        f_rd_en = 1'b0;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                if (start && !done_q) begin
                    state_n = WLOAD;
                    k_n     = '0;
                    row_n   = '0;
                    col_n   = '0;
                end
            end
            WLOAD: begin
                w_rd_en = 1'b1;
                if (k == K_END) begin
                    state_n = HEAD;
                    k_n     = '0;
                end else begin
                    k_n = k + 4'd1;
                end
            end
            HEAD: begin
                f_rd_en = room;
                if (room) begin
                    if (row == '0) begin
                        row_n = RW'(1);
                    end else if (col != COL_END) begin
                        row_n = '0;
                        col_n = col + CW'(1);
                    end else if (ROW == 2) begin
                        state_n = DRAIN;
                    end else begin
                        state_n = BODY;
                        row_n   = RW'(2);
                        col_n   = COL_END;
                    end
                end
            end
            BODY: begin
                f_rd_en = room;
                if (room) begin
                    // Even rows walk right-to-left, odd rows left-to-right.
                    if (!row[0]) begin
                        if (col != '0) begin
                            col_n = col - CW'(1);
                        end else if (row == ROW_END) begin
                            state_n = DRAIN;
                        end else begin
                            row_n = row + RW'(1);
                            col_n = '0;
                        end
                    end else begin
                        if (col != COL_END) begin
                            col_n = col + CW'(1);
                        end else if (row == ROW_END) begin
                            state_n = DRAIN;
                        end else begin
                            row_n = row + RW'(1);
                            col_n = COL_END;
                        end
                    end
                end
            end
            DRAIN: begin
                if (accept && data_last) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                    row_n   = '0;
                    col_n   = '0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            k       <= '0;
            row     <= '0;
            col     <= '0;
            beat    <= '0;
            wv      <= 1'b0;
            rd_pend <= 1'b0;
            done_q  <= 1'b0;
            occ     <= '0;
            rd_ptr  <= 1'b0;
            wr_ptr  <= 1'b0;
            fifo[0] <= '0;
            fifo[1] <= '0;
        end else begin
            state   <= state_n;
            k       <= k_n;
            row     <= row_n;
            col     <= col_n;
            wv      <= w_rd_en;
            rd_pend <= f_rd_en;
            done_q  <= done_n;
            if (state == IDLE) begin
                beat <= '0;
            end else if (accept) begin
                beat <= beat + BW'(1);
            end
            if (push) begin
                fifo[wr_ptr] <= f_rdata;
                wr_ptr       <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            occ <= occ + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_snake_feeder_ctrl.sv
// Scoreboard bench: expected weights, addresses and beats are queued at start and popped by negedge monitors.
module tb_snake_feeder_ctrl;
    localparam int ROW = 4, COL = 4, DW = 32, WW = 768, NW = 12, AW = 4;
    localparam int ROW_B = 2, COL_B = 3, AW_B = 3;
    typedef int int_q_t[$];

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, busy, done, w_rd_en, weight_valid, f_rd_en, data_valid, data_ready, data_last;
    logic [3:0] w_addr;
    logic [WW-1:0] w_rdata, weight_out;
    logic [AW-1:0] f_addr;
    logic [DW-1:0] f_rdata, data_out;

    logic start_b, busy_b, done_b, w_rd_en_b, weight_valid_b, f_rd_en_b, data_valid_b, data_last_b;
    logic [3:0] w_addr_b;
    logic [WW-1:0] w_rdata_b, weight_out_b;
    logic [AW_B-1:0] f_addr_b;
    logic [DW-1:0] f_rdata_b, data_out_b;

    snake_feeder_ctrl #(.ROW(ROW), .COL(COL), .DW(DW), .WW(WW), .NW(NW), .AW(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .w_rd_en(w_rd_en), .w_addr(w_addr), .w_rdata(w_rdata),
        .weight_out(weight_out), .weight_valid(weight_valid),
        .f_rd_en(f_rd_en), .f_addr(f_addr), .f_rdata(f_rdata),
        .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready), .data_last(data_last));

    snake_feeder_ctrl #(.ROW(ROW_B), .COL(COL_B), .DW(DW), .WW(WW), .NW(NW), .AW(AW_B)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
        .w_rd_en(w_rd_en_b), .w_addr(w_addr_b), .w_rdata(w_rdata_b),
        .weight_out(weight_out_b), .weight_valid(weight_valid_b),
        .f_rd_en(f_rd_en_b), .f_addr(f_addr_b), .f_rdata(f_rdata_b),
        .data_out(data_out_b), .data_valid(data_valid_b), .data_ready(1'b1), .data_last(data_last_b));

    int n_chk = 0, n_fail = 0;
    int frames = 0, frames_b = 0, beats_acc = 0, rd_cnt = 0, out_cnt = 0, mode = 0, stall_left = 10;
    logic [31:0] seed = 32'h1234_5678;
    logic exp_done = 1'b0, exp_done_b = 1'b0, prev_stall = 1'b0, first_rd = 1'b0, acc, nxt_last;
    logic [DW:0] prev_beat;
    logic [WW-1:0] wq[$];
    int aq[$], aq_b[$];
    logic [DW:0] dq[$], dq_b[$];
    int_q_t ob;

    task automatic check(input string name, input logic [WW-1:0] got, input logic [WW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] fdat(input int a, input logic [31:0] s);
        return s ^ (32'(a) * 32'h9E37_79B1) ^ 32'h0000_00A5;
    endfunction

    function automatic logic [WW-1:0] wdat(input int k, input logic [31:0] s);
        logic [31:0] w;
        w = s ^ (32'(k) * 32'h0101_0101) ^ 32'h3C00_0000;
        return {24{w}};
    endfunction

    // Reference traversal: two-row zig-zag head, then rows alternate direction starting right-to-left.
    function automatic int_q_t snake_order(input int r, input int c);
        int_q_t q;
        for (int j = 0; j < c; j++) begin
            q.push_back(j);
            q.push_back(c + j);
        end
        for (int i = 2; i < r; i++)
            for (int j = 0; j < c; j++)
                q.push_back(i * c + ((i % 2 == 0) ? (c - 1 - j) : j));
        return q;
    endfunction

    always @(posedge clk) begin
        f_rdata   <= f_rd_en ? fdat(int'(f_addr), seed) : $urandom;
        w_rdata   <= w_rd_en ? wdat(int'(w_addr), seed) : wdat($urandom_range(100, 200), seed);
        f_rdata_b <= f_rd_en_b ? fdat(int'(f_addr_b), seed) : $urandom;
        w_rdata_b <= wdat(int'(w_addr_b), seed);
    end

    initial begin
        data_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (mode)
                0: data_ready = 1'b1;
                1: data_ready = ~data_ready;
                2: data_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (beats_acc < 5) stall_left = 10;
                    if (beats_acc == 5 && stall_left > 0) begin
                        data_ready = 1'b0;
                        stall_left--;
                    end else begin
                        data_ready = 1'b1;
                    end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            exp_done = 1'b0; out_cnt = 0; prev_stall = 1'b0; first_rd = 1'b0;
        end else begin
            acc = data_valid & data_ready;
            check("done", done, exp_done);
            if (exp_done) begin
                check("busy_at_done", busy, 0);
                frames++;
            end
            if (!busy) begin
                beats_acc = 0;
                rd_cnt = 0;
            end
            if (first_rd) check("first_latency", data_valid, 1);
            first_rd = f_rd_en && rd_cnt == 0;
            if (weight_valid) begin
                if (wq.size() == 0) check("weight_extra", weight_valid, 0);
                else check("weight", weight_out, wq.pop_front());
            end
            if (f_rd_en) begin
                check("outstanding", (out_cnt + 1 - int'(acc)) <= 2, 1);
                if (aq.size() == 0) check("read_extra", f_rd_en, 0);
                else check("f_addr", f_addr, aq.pop_front());
                rd_cnt++;
            end
            if (prev_stall) begin
                check("stall_valid", data_valid, 1);
                check("stall_beat", {data_last, data_out}, prev_beat);
            end
            exp_done = 1'b0;
            if (acc) begin
                if (dq.size() == 0) check("beat_extra", acc, 0);
                else begin
                    nxt_last = dq[0][DW];
                    check("beat", {data_last, data_out}, dq.pop_front());
                    exp_done = nxt_last;
                end
                beats_acc++;
            end
            out_cnt += int'(f_rd_en) - int'(acc);
            prev_stall = data_valid & ~data_ready;
            prev_beat = {data_last, data_out};
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            exp_done_b = 1'b0;
        end else begin
            check("b_done", done_b, exp_done_b);
            if (exp_done_b) frames_b++;
            if (f_rd_en_b) begin
                if (aq_b.size() == 0) check("b_read_extra", f_rd_en_b, 0);
                else check("b_f_addr", f_addr_b, aq_b.pop_front());
            end
            exp_done_b = 1'b0;
            if (data_valid_b) begin
                if (dq_b.size() == 0) check("b_beat_extra", data_valid_b, 0);
                else begin
                    exp_done_b = dq_b[0][DW];
                    check("b_beat", {data_last_b, data_out_b}, dq_b.pop_front());
                end
            end
        end
    end

    task automatic expect_frame();
        logic lst;
        ob = snake_order(ROW, COL);
        for (int k = 0; k < NW; k++) wq.push_back(wdat(k, seed));
        foreach (ob[i]) begin
            lst = (i == ob.size() - 1);
            aq.push_back(ob[i]);
            dq.push_back({lst, fdat(ob[i], seed)});
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        check("busy_after_start", busy, 1);
    endtask

    task automatic wait_frame(input int f0);
        for (int i = 0; i < 3000 && frames == f0; i++) @(posedge clk);
        check("frame_done", frames - f0, 1);
        check("queues_empty", wq.size() + aq.size() + dq.size(), 0);
    endtask

    task automatic run_frame(input int m);
        int f0;
        mode = m;
        seed = $urandom;
        f0 = frames;
        expect_frame();
        pulse_start();
        wait_frame(f0);
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_w_rd_en"}, w_rd_en, 0);
        check({tag, "_w_addr"}, w_addr, 0);
        check({tag, "_weight_valid"}, weight_valid, 0);
        check({tag, "_weight_out"}, weight_out, 0);
        check({tag, "_f_rd_en"}, f_rd_en, 0);
        check({tag, "_f_addr"}, f_addr, 0);
        check({tag, "_data_valid"}, data_valid, 0);
        check({tag, "_data_out"}, data_out, 0);
        check({tag, "_data_last"}, data_last, 0);
    endtask

    initial begin
        int f0;
        rst = 1'b1; start = 1'b0; start_b = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_checks("rst");
        @(posedge clk); #1 rst = 1'b0;

        run_frame(0);
        run_frame(1);
        run_frame(3);
        run_frame(2);

        // Abort a frame in its serpentine body, then restart cleanly.
        mode = 0;
        seed = $urandom;
        expect_frame();
        pulse_start();
        for (int i = 0; i < 500 && beats_acc < 9; i++) @(posedge clk);
        check("reached_body", beats_acc >= 9, 1);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        wq.delete(); aq.delete(); dq.delete();
        @(negedge clk);
        reset_checks("mid_rst");
        run_frame(2);

        // Stray starts during weight load and on the done cycle.
        mode = 0;
        seed = $urandom;
        f0 = frames;
        expect_frame();
        pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(posedge clk); #1;
        end
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        check("start_with_done_ignored", busy, 0);
        repeat (20) @(posedge clk);
        check("one_frame", frames - f0, 1);
        check("idle_after", busy, 0);
        check("queues_empty_after", wq.size() + aq.size() + dq.size(), 0);

        // Two-row map: head only, no body.
        seed = $urandom;
        ob = snake_order(ROW_B, COL_B);
        foreach (ob[i]) begin
            aq_b.push_back(ob[i]);
            dq_b.push_back({1'(i == ob.size() - 1), fdat(ob[i], seed)});
        end
        f0 = frames_b;
        @(posedge clk); #1 start_b = 1'b1;
        @(posedge clk); #1 start_b = 1'b0;
        for (int i = 0; i < 3000 && frames_b == f0; i++) @(posedge clk);
        check("b_frame_done", frames_b - f0, 1);
        check("b_queues_empty", aq_b.size() + dq_b.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
